// File: rtl/hc595_ctrl.sv
// hc595_ctrl: serialiser from the static segment driver to two cascaded 74HC595s.
//
// Each frame snapshots W = {seg, sel} (14 bits), shifts it out MSB first on
// ds/shcp, pulses stcp to latch it into the 595 outputs, then drives oe low.
// Frames repeat back to back (2 + 15*CLK_DIV sys_clk cycles each), so upstream
// changes appear within one frame.
//
// Optional feature, macro HC595_CHANGE_ONLY_EN: when defined, a frame is only
// started when W differs from the last word sent (or for the first frame after
// reset); otherwise the serial lines stay idle.
//
// Parameters:
//   CLK_DIV     sys_clk cycles per shifted bit; even, >= 2
//
// Ports:
//   sys_clk     system clock
//   sys_rst_n   asynchronous active-low reset
//   sel[5:0]    digit select, sampled only in LOAD
//   seg[7:0]    segment pattern (active-low), sampled only in LOAD
//   ds          serial data to 595 DS
//   shcp        shift clock to 595 SHCP
//   stcp        storage clock to 595 STCP
//   oe          595 output enable, active-low; low once the first frame is latched
//   frame_done  one-cycle pulse on the final LATCH cycle

module hc595_ctrl #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [5:0] sel,
  input  logic [7:0] seg,
  output logic       ds,
  output logic       shcp,
  output logic       stcp,
  output logic       oe,
  output logic       frame_done
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0] DivHalf = DivW'(CLK_DIV / 2);
  localparam logic [DivW-1:0] DivOne  = DivW'(1);
  localparam logic [3:0]      BitLast = 4'd13;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StLatch
  } state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_cnt_q, div_cnt_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [13:0]       shreg_q, shreg_d;

  logic              ds_q, ds_d;
  logic              shcp_q, shcp_d;
  logic              stcp_q, stcp_d;
  logic              oe_q, oe_d;
  logic              frame_done_q, frame_done_d;

  logic [13:0]       word;
  logic              start_ok;
  logic              latch_end;

  assign word      = {seg, sel};
  assign latch_end = (state_q == StLatch) && (div_cnt_q == DivLast);

`ifdef HC595_CHANGE_ONLY_EN
  logic [13:0] last_sent_q, last_sent_d;
  logic        first_q, first_d;

  // The first frame after reset always goes out so oe can be enabled.
  assign start_ok = first_q || (word != last_sent_q);

  always_comb begin
    last_sent_d = last_sent_q;
    first_d     = first_q;
    if (state_q == StLoad) begin
      last_sent_d = word;
      first_d     = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      last_sent_q <= '0;
      first_q     <= 1'b1;
    end else begin
      last_sent_q <= last_sent_d;
      first_q     <= first_d;
    end
  end
`else
  assign start_ok = 1'b1;
`endif

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;

    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d = StLoad;
        end
      end

      StLoad: begin
        shreg_d   = word;
        bit_cnt_d = '0;
        div_cnt_d = '0;
        state_d   = StShift;
      end

      StShift: begin
        if (div_cnt_q == DivLast) begin
          div_cnt_d = '0;
          shreg_d   = {shreg_q[12:0], 1'b0};
          // bit_cnt saturates at the last bit rather than wrapping.
          if (bit_cnt_q == BitLast) begin
            state_d = StLatch;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          div_cnt_d = div_cnt_q + DivOne;
        end
      end

      StLatch: begin
        if (div_cnt_q == DivLast) begin
          div_cnt_d = '0;
          state_d   = StIdle;
        end else begin
          div_cnt_d = div_cnt_q + DivOne;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from the next-state view and registered, so each output
  // register lines up with the state/counter registers on the same edge.
  always_comb begin
    ds_d         = 1'b0;
    shcp_d       = 1'b0;
    stcp_d       = 1'b0;
    frame_done_d = 1'b0;
    oe_d         = oe_q;

    unique case (state_d)
      StShift: begin
        ds_d   = shreg_d[13];
        shcp_d = (div_cnt_d >= DivHalf);
      end
      StLatch: begin
        ds_d         = ds_q;
        stcp_d       = (div_cnt_d < DivHalf);
        frame_done_d = (div_cnt_d == DivLast);
      end
      default: begin
        ds_d = 1'b0;
      end
    endcase

    // oe drops on the edge that ends the final LATCH cycle and stays low.
    if (latch_end) begin
      oe_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= StIdle;
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      ds_q         <= 1'b0;
      shcp_q       <= 1'b0;
      stcp_q       <= 1'b0;
      oe_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      ds_q         <= ds_d;
      shcp_q       <= shcp_d;
      stcp_q       <= stcp_d;
      oe_q         <= oe_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ds         = ds_q;
  assign shcp       = shcp_q;
  assign stcp       = stcp_q;
  assign oe         = oe_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hc595_ctrl.sv
// tb_hc595_ctrl: self-checking bench for hc595_ctrl.
//
// Two DUTs share clock and reset: u_dut (CLK_DIV=4) driven by the stimulus
// sequence, and u_dut_div2 (CLK_DIV=2) fed a constant word. A behavioural 595
// model per DUT shifts ds on shcp rising and latches on stcp rising; expected
// words for u_dut are queued when inputs are set and popped on frame_done.
// Builds with or without HC595_CHANGE_ONLY_EN.

module tb_hc595_ctrl;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [5:0] sel, sel2;
  logic [7:0] seg, seg2;
  logic       ds, shcp, stcp, oe, frame_done;
  logic       ds2, shcp2, stcp2, oe2, frame_done2;

  int n_vec = 0;
  int n_err = 0;

  logic [13:0] sb[$];
  logic        sb_on;

  localparam logic [13:0] Div2Word = {8'h92, 6'h2A};

  hc595_ctrl #(.CLK_DIV(4)) u_dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .sel       (sel),
    .seg       (seg),
    .ds        (ds),
    .shcp      (shcp),
    .stcp      (stcp),
    .oe        (oe),
    .frame_done(frame_done)
  );

  hc595_ctrl #(.CLK_DIV(2)) u_dut_div2 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .sel       (sel2),
    .seg       (seg2),
    .ds        (ds2),
    .shcp      (shcp2),
    .stcp      (stcp2),
    .oe        (oe2),
    .frame_done(frame_done2)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // 595 model and protocol monitor state, index 0 = u_dut, 1 = u_dut_div2.
  logic [13:0] sr [2];
  logic [13:0] latched [2];
  logic        prev_shcp [2];
  logic        prev_stcp [2];
  logic        prev_ds [2];
  logic        prev_fd [2];
  logic        first_fd [2];
  int          shcp_rises [2];
  int          stcp_rises [2];
  int          shcp_hi [2];
  int          stcp_hi [2];
  int          cyc [2];
  int          last_fd [2];

  task automatic mon(input int k, input int div, input string pfx, input logic rst_n,
                     input logic d, input logic sh, input logic st, input logic fd,
                     input logic oe_v);
    logic [13:0] exp_w;
    if (!rst_n) begin
      prev_shcp[k]  = 1'b0;
      prev_stcp[k]  = 1'b0;
      prev_ds[k]    = 1'b0;
      prev_fd[k]    = 1'b0;
      first_fd[k]   = 1'b1;
      shcp_rises[k] = 0;
      stcp_rises[k] = 0;
      shcp_hi[k]    = 0;
      stcp_hi[k]    = 0;
      cyc[k]        = 0;
      last_fd[k]    = -1;
      return;
    end
    cyc[k]++;

    if (sh && !prev_shcp[k]) begin
      check({pfx, "_ds_stable_at_shcp"}, d, prev_ds[k]);
      sr[k] = {sr[k][12:0], d};
      shcp_rises[k]++;
    end
    if (sh) begin
      shcp_hi[k]++;
    end else if (prev_shcp[k]) begin
      check({pfx, "_shcp_high_width"}, shcp_hi[k], div / 2);
      shcp_hi[k] = 0;
    end

    if (st && !prev_stcp[k]) begin
      latched[k] = sr[k];
      stcp_rises[k]++;
    end
    if (st) begin
      stcp_hi[k]++;
    end else if (prev_stcp[k]) begin
      check({pfx, "_stcp_high_width"}, stcp_hi[k], div / 2);
      stcp_hi[k] = 0;
    end

    if (prev_fd[k]) check({pfx, "_oe_after_fd"}, oe_v, 1'b0);

    if (fd) begin
      check({pfx, "_shcp_edges"}, shcp_rises[k], 14);
      check({pfx, "_stcp_pulses"}, stcp_rises[k], 1);
      if (first_fd[k]) check({pfx, "_oe_at_first_fd"}, oe_v, 1'b1);
      first_fd[k] = 1'b0;
`ifndef HC595_CHANGE_ONLY_EN
      if (last_fd[k] >= 0) check({pfx, "_frame_period"}, cyc[k] - last_fd[k], 2 + 15 * div);
`endif
      last_fd[k] = cyc[k];
      if (k == 0) begin
        if (sb_on) begin
          if (sb.size() == 0) begin
            check({pfx, "_scoreboard_underflow"}, sb.size(), 1);
          end else begin
            exp_w = sb.pop_front();
            check({pfx, "_latched_word"}, latched[k], exp_w);
          end
        end
      end else begin
        check({pfx, "_latched_word"}, latched[k], Div2Word);
      end
      shcp_rises[k] = 0;
      stcp_rises[k] = 0;
    end

    prev_shcp[k] = sh;
    prev_stcp[k] = st;
    prev_ds[k]   = d;
    prev_fd[k]   = fd;
  endtask

  always @(negedge sys_clk) begin
    mon(0, 4, "div4", sys_rst_n, ds, shcp, stcp, frame_done, oe);
    mon(1, 2, "div2", sys_rst_n, ds2, shcp2, stcp2, frame_done2, oe2);
  end

  task automatic wait_fd(input int budget);
    int n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!frame_done && n < budget);
    if (!frame_done) check("frame_done_timeout", frame_done, 1'b1);
  endtask

  // Releases reset at a negedge and measures cycles until oe is enabled.
  task automatic release_timed();
    int n = 0;
    sb.push_back({seg, sel});
    sys_rst_n = 1'b1;
    do begin
      @(negedge sys_clk);
      n++;
    end while (oe && n < 200);
    check("oe_enable_latency", n, 62);
  endtask

  task automatic next_frame(input logic [7:0] seg_v, input logic [5:0] sel_v);
    wait_fd(200);
    seg = seg_v;
    sel = sel_v;
    sb.push_back({seg, sel});
  endtask

  task automatic quiet(input int n_cyc, input string tag);
    int act = 0;
    repeat (n_cyc) begin
      @(negedge sys_clk);
      if (shcp || stcp || frame_done || ds) act++;
    end
    check(tag, act, 0);
  endtask

  logic [7:0] codes [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  initial begin
    logic [13:0] exp_last;
    sys_rst_n = 1'b0;
    sel       = '0;
    seg       = '0;
    sel2      = 6'h2A;
    seg2      = 8'h92;
    sb_on     = 1'b1;

    repeat (3) @(negedge sys_clk);
    check("rst_ds", ds, 1'b0);
    check("rst_shcp", shcp, 1'b0);
    check("rst_stcp", stcp, 1'b0);
    check("rst_oe", oe, 1'b1);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_oe_div2", oe2, 1'b1);

`ifdef HC595_CHANGE_ONLY_EN
    sel = 6'h3F;
    seg = 8'hA4;
    release_timed();
    quiet(500, "idle_after_first_frame");
    seg = 8'hB0;
    sb.push_back({seg, sel});
    wait_fd(200);
    quiet(500, "idle_after_change_frame");
    sb_on = 1'b0;
    check("scoreboard_drained", sb.size(), 0);
`else
    // First frame after reset, then a second frame with the same word.
    sel = 6'h3F;
    seg = 8'hC0;
    release_timed();
    sb.push_back({seg, sel});

    // Change seg at bit 5 of a frame: that frame keeps C0, the next gets F9.
    wait_fd(200);
    sb.push_back({seg, sel});
    repeat (23) @(negedge sys_clk);
    seg = 8'hF9;
    sb.push_back({seg, sel});
    wait_fd(200);

    for (int i = 0; i < 16; i++) begin
      next_frame(codes[i], 6'(i * 11));
    end
    wait_fd(200);
    exp_last = {seg, sel};

    // Reset at bit 9 (second half of the window) of the next frame.
    repeat (41) @(negedge sys_clk);
    check("pre_rst_shcp", shcp, 1'b1);
    check("pre_rst_oe", oe, 1'b0);
    #2 sys_rst_n = 1'b0;
    #1;
    check("async_rst_ds", ds, 1'b0);
    check("async_rst_shcp", shcp, 1'b0);
    check("async_rst_stcp", stcp, 1'b0);
    check("async_rst_oe", oe, 1'b1);
    check("async_rst_oe_div2", oe2, 1'b1);
    repeat (3) @(negedge sys_clk);
    check("partial_frame_not_latched", latched[0], exp_last);
    release_timed();
    sb.push_back({seg, sel});
    wait_fd(200);
    #1 sb_on = 1'b0;
    check("scoreboard_drained", sb.size(), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
